mem_req_queue: RTL

Client-side request buffer that sits directly upstream of the memory clock-domain crossing, in the client clock domain. It accepts single-word read/write requests from local logic through a valid/ready handshake, stores them in a small FIFO, and issues them one at a time on a `mem_port_if` controller port. It holds each strobe until the single-cycle `ready` pulse returns, then returns read data to the requester.

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/mem_port_if.sv | 27 ++
 rtl/mem_req_fifo.sv | 42 ++++
 rtl/mem_req_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared request type and FSM state encoding for the memory request queue.
// The request struct widths match the default mem_port_if widths (21-bit address, 32-bit data).
package mem_req_pkg;

  localparam int REQ_ADDR_W = 21;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_BE_W   = REQ_DATA_W / 8;

  typedef struct packed {
    logic                  wr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_BE_W-1:0]   byte_en;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } mem_req_state_t;

endpackage

// File: rtl/mem_port_if.sv
// Single-word memory port between a client controller and the memory clock-domain crossing.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic                    wr;
  logic                    rd;
  logic                    burst;
  logic [DATA_WIDTH-1:0]   q;
  logic                    ready;
  logic                    available;

  modport controller (
    output addr, data, byte_en, wr, rd, burst,
    input  q, ready, available
  );

  modport memory (
    input  addr, data, byte_en, wr, rd, burst,
    output q, ready, available
  );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO of mem_req_t; pointers carry one extra wrap bit so full and empty
// are told apart by the MSB compare.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t wdata,
  output mem_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  mem_req_t    store [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = store[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Client-side request buffer feeding one request at a time onto a mem_port_if controller port.
// Optional watchdog enabled by defining MEM_REQ_QUEUE_TIMEOUT_EN (adds the sticky timeout port).
//
// state | meaning
// IDLE  | waiting for a queued request and mem.available; pops the head into the issue register
// ISSUE | rd or wr strobe held high until the memory returns ready (or the watchdog expires)
// DONE  | strobes low, rsp_valid pulses for a completed read; always returns to IDLE
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy,
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
  output logic                    timeout,
`endif
  mem_port_if.controller          mem
);

  mem_req_state_t state;
  mem_req_t       push_word;
  mem_req_t       head;
  mem_req_t       iss;
  logic           full;
  logic           empty;
  logic           pop;

  assign push_word = {req_wr, req_addr, req_data, req_byte_en};
  assign pop       = (state == IDLE) && !empty && mem.available;
  assign req_ready = !full;
  assign busy      = !empty || (state != IDLE);

  assign mem.addr    = iss.addr;
  assign mem.data    = iss.data;
  assign mem.byte_en = iss.byte_en;
  assign mem.burst   = 1'b0;

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iss       <= '0;
      mem.rd    <= 1'b0;
      mem.wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            iss    <= head;
            mem.rd <= !head.wr;
            mem.wr <= head.wr;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
            wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem.ready) begin
            mem.rd <= 1'b0;
            mem.wr <= 1'b0;
            if (!iss.wr) begin
              rsp_data  <= mem.q;
              rsp_valid <= 1'b1;
            end
            state <= DONE;
          end
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
          // Abandoned reads still complete so the requester never waits forever.
          else if (wd_cnt == '0) begin
            mem.rd  <= 1'b0;
            mem.wr  <= 1'b0;
            timeout <= 1'b1;
            if (!iss.wr) begin
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
            end
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt - TW'(1);
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
